// File: rtl/i2c_pkg.sv
// Shared I2C master types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: shifter FSM state enum, default frame width.
package i2c_pkg;

  localparam int I2C_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } shifter_state_t;

endpackage

// File: rtl/i2c_edge_det.sv
// SCL edge detector: one-register history of the synchronised SCL pad level.
// Latency: rise/fall are combinational in the cycle the new level first appears.
// Backpressure: none; edges are single-cycle strobes.
// Ports: i_clk, i_rst (sync, active-high), i_scl (pad level),
//        o_rise / o_fall (mutually exclusive edge strobes).
module i2c_edge_det #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  output logic o_rise,
  output logic o_fall
);

  logic r_scl_q;

  // Reset high: an idle bus reads high, so leaving reset never fakes an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_q <= RESET_VAL;
    end else begin
      r_scl_q <= i_scl;
    end
  end

  assign o_rise = i_scl & ~r_scl_q;
  assign o_fall = ~i_scl & r_scl_q;

endmodule

// File: rtl/i2c_byte_shifter.sv
// SDA byte shift engine: shifts one byte MSB-first out or in, then runs the ACK clock.
// Latency: SDA drive updates one pclk after the SCL edge is seen; result pulses one pclk after the ACK-slot fall.
// Backpressure: byte_start honoured only while busy=0; SCL stretching just delays edges.
// Ports: pclk/preset (sync, active-high); scl_pad_i/sda_pad_i pad levels;
//        byte_start/byte_dir/tx_data/ack_to_send request, abort;
//        sda_pad_oe open-drain pull-down, busy, byte_done, rx_data, ack_received, arb_lost.
module i2c_byte_shifter
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  scl_pad_i,
  input  logic                  sda_pad_i,
  input  logic                  byte_start,
  input  logic                  byte_dir,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  ack_to_send,
  input  logic                  abort,
  output logic                  sda_pad_oe,
  output logic                  busy,
  output logic                  byte_done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  ack_received,
  output logic                  arb_lost
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH);

  logic w_scl_rise;
  logic w_scl_fall;

  shifter_state_t r_state, w_state_nxt;
  logic                  r_dir,      w_dir_nxt;
  logic                  r_ack_send, w_ack_send_nxt;
  logic [DATA_WIDTH-1:0] r_shift,    w_shift_nxt;
  logic [CNT_W-1:0]      r_cnt,      w_cnt_nxt;
  logic                  r_oe,       w_oe_nxt;
  logic                  r_done,     w_done_nxt;
  logic                  r_arb,      w_arb_nxt;
  logic [DATA_WIDTH-1:0] r_rx,       w_rx_nxt;
  logic                  r_ack_rx,   w_ack_rx_nxt;

  i2c_edge_det #(
    .RESET_VAL (1'b1)
  ) u_edge_det (
    .i_clk  (pclk),
    .i_rst  (preset),
    .i_scl  (scl_pad_i),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state    <= IDLE;
      r_dir      <= 1'b0;
      r_ack_send <= 1'b1;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_oe       <= 1'b0;
      r_done     <= 1'b0;
      r_arb      <= 1'b0;
      r_rx       <= '0;
      r_ack_rx   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_ack_send <= w_ack_send_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_oe       <= w_oe_nxt;
      r_done     <= w_done_nxt;
      r_arb      <= w_arb_nxt;
      r_rx       <= w_rx_nxt;
      r_ack_rx   <= w_ack_rx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_dir_nxt      = r_dir;
    w_ack_send_nxt = r_ack_send;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_done_nxt     = 1'b0;
    w_arb_nxt      = 1'b0;
    w_rx_nxt       = r_rx;
    w_ack_rx_nxt   = r_ack_rx;
    w_oe_nxt       = 1'b0;

    if (abort) begin
      // Abort beats everything, including a same-cycle byte_start.
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (byte_start) begin
            w_state_nxt    = SHIFT;
            w_dir_nxt      = byte_dir;
            w_shift_nxt    = tx_data;
            w_ack_send_nxt = ack_to_send;
            w_cnt_nxt      = '0;
          end
        end

        SHIFT: begin
          // Guard on the count so a stray extra high can never push past the frame.
          if (w_scl_rise && (r_cnt != CNT_LAST)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_dir) begin
              w_shift_nxt = {r_shift[DATA_WIDTH-2:0], sda_pad_i};
            end else if (r_shift[DATA_WIDTH-1] && !sda_pad_i) begin
              // We released SDA for a 1 but someone else holds it low.
              w_arb_nxt   = 1'b1;
              w_state_nxt = IDLE;
            end
          end else if (w_scl_fall) begin
            if (r_cnt == CNT_LAST) begin
              w_state_nxt = ACK;
            end else if (!r_dir) begin
              w_shift_nxt = {r_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end

        ACK: begin
          if (w_scl_rise && !r_dir) begin
            w_ack_rx_nxt = sda_pad_i;
          end else if (w_scl_fall) begin
            if (r_dir) begin
              w_rx_nxt = r_shift;
            end
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end

        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end

    // Drive is derived from next-cycle state so the pad output is a clean flop
    // that only moves on the pclk after an SCL fall (or on accept/abort/loss).
    if ((w_state_nxt == SHIFT) && !w_dir_nxt) begin
      w_oe_nxt = ~w_shift_nxt[DATA_WIDTH-1];
    end else if ((w_state_nxt == ACK) && w_dir_nxt) begin
      w_oe_nxt = ~w_ack_send_nxt;
    end
  end

  assign sda_pad_oe   = r_oe;
  assign busy         = (r_state != IDLE);
  assign byte_done    = r_done;
  assign arb_lost     = r_arb;
  assign rx_data      = r_rx;
  assign ack_received = r_ack_rx;

endmodule

// File: tb/tb_i2c_byte_shifter.sv
// Self-checking bench for i2c_byte_shifter: bench drives SCL and acts as the slave on an open-drain SDA.
module tb_i2c_byte_shifter;

  logic       pclk = 1'b0;
  logic       preset;
  logic       scl;
  logic       slave_low;
  logic       byte_start;
  logic       byte_dir;
  logic [7:0] tx_data;
  logic       ack_to_send;
  logic       abort;
  logic       sda_pad_oe;
  logic       busy;
  logic       byte_done;
  logic [7:0] rx_data;
  logic       ack_received;
  logic       arb_lost;
  logic       sda_line;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_arb   = 0;
  logic [7:0] exp_rx = 8'h00;

  // Wired-AND bus: low if either master or slave pulls.
  assign sda_line = ~(sda_pad_oe | slave_low);

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (byte_done === 1'b1) n_done <= n_done + 1;
    if (arb_lost === 1'b1) n_arb <= n_arb + 1;
  end

  i2c_byte_shifter #(.DATA_WIDTH(8)) dut (
    .pclk         (pclk),
    .preset       (preset),
    .scl_pad_i    (scl),
    .sda_pad_i    (sda_line),
    .byte_start   (byte_start),
    .byte_dir     (byte_dir),
    .tx_data      (tx_data),
    .ack_to_send  (ack_to_send),
    .abort        (abort),
    .sda_pad_oe   (sda_pad_oe),
    .busy         (busy),
    .byte_done    (byte_done),
    .rx_data      (rx_data),
    .ack_received (ack_received),
    .arb_lost     (arb_lost)
  );

  task automatic start_byte(input bit dir, input logic [7:0] d, input bit ats);
    byte_dir    = dir;
    tx_data     = d;
    ack_to_send = ats;
    byte_start  = 1'b1;
    @(negedge pclk);
    byte_start  = 1'b0;
  endtask

  // Clocks nbits SCL periods. Slave drives the byte (RX) and the ACK (TX, ACK=0 pulls low).
  // Records the bus level in each high phase and whether the master drive moved while SCL was high.
  task automatic clock_bits(input bit dir, input logic [7:0] slave_byte, input bit slave_ack,
                            input int nbits, input int stretch_idx, input int stretch_len,
                            output logic [7:0] seen, output logic ack_oe, output bit stable);
    int lo;
    int hi;
    bit pull;
    logic ln;
    logic o0;
    seen   = 8'h00;
    ack_oe = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      lo = $urandom_range(3, 6);
      hi = $urandom_range(3, 6);
      if (i == stretch_idx) lo = lo + stretch_len;
      if (i < 8) pull = dir ? ~slave_byte[7-i] : 1'b0;
      else       pull = dir ? 1'b0 : ~slave_ack;
      scl = 1'b0;
      slave_low = pull;
      repeat (lo) @(negedge pclk);
      scl = 1'b1;
      @(negedge pclk);
      ln = sda_line;
      o0 = sda_pad_oe;
      for (int k = 1; k < hi; k++) begin
        @(negedge pclk);
        if (sda_pad_oe !== o0) stable = 1'b0;
      end
      if (i < 8) seen[7-i] = ln;
      else       ack_oe    = o0;
    end
    scl = 1'b0;
    slave_low = 1'b0;
  endtask

  task automatic test_reset;
    preset = 1'b1; scl = 1'b1; slave_low = 1'b0; byte_start = 1'b0;
    byte_dir = 1'b0; tx_data = 8'h00; ack_to_send = 1'b1; abort = 1'b0;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    n_tests++; if (sda_pad_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", sda_pad_oe); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (byte_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", byte_done); end
    n_tests++; if (arb_lost !== 1'b0) begin n_fail++; $display("FAIL reset_arb got=%b exp=0", arb_lost); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx got=%h exp=00", rx_data); end
    n_tests++; if (ack_received !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ack_received); end
    scl = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic test_tx_a5;
    logic [7:0] seen; logic aoe; bit st;
    start_byte(1'b0, 8'hA5, 1'b1);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tx_a5_busy got=%b exp=1", busy); end
    clock_bits(1'b0, 8'h00, 1'b0, 9, -1, 0, seen, aoe, st);
    n_tests++; if (seen !== 8'hA5) begin n_fail++; $display("FAIL tx_a5_bits got=%h exp=a5", seen); end
    n_tests++; if (aoe !== 1'b0) begin n_fail++; $display("FAIL tx_a5_ack_release got=%b exp=0", aoe); end
    n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL tx_a5_stable got=%b exp=1", st); end
    @(negedge pclk);
    n_tests++; if (byte_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL tx_a5_done got=%b/%b exp=1/0", byte_done, busy); end
    n_tests++; if (ack_received !== 1'b0) begin n_fail++; $display("FAIL tx_a5_ackrx got=%b exp=0", ack_received); end
    @(negedge pclk);
    n_tests++; if (byte_done !== 1'b0) begin n_fail++; $display("FAIL tx_a5_pulse got=%b exp=0", byte_done); end
  endtask

  task automatic test_rx_nack;
    logic [7:0] seen; logic aoe; bit st;
    start_byte(1'b1, 8'h00, 1'b1);
    n_tests++; if (sda_pad_oe !== 1'b0) begin n_fail++; $display("FAIL rx_oe_start got=%b exp=0", sda_pad_oe); end
    clock_bits(1'b1, 8'h3C, 1'b0, 9, -1, 0, seen, aoe, st);
    @(negedge pclk);
    exp_rx = 8'h3C;
    n_tests++; if (byte_done !== 1'b1) begin n_fail++; $display("FAIL rx_done got=%b exp=1", byte_done); end
    n_tests++; if (rx_data !== exp_rx) begin n_fail++; $display("FAIL rx_data got=%h exp=%h", rx_data, exp_rx); end
    n_tests++; if (aoe !== 1'b0) begin n_fail++; $display("FAIL rx_nack_oe got=%b exp=0", aoe); end
  endtask

  task automatic test_rx_ack0;
    logic [7:0] seen; logic aoe; bit st;
    int bad;
    start_byte(1'b1, 8'h00, 1'b0);
    clock_bits(1'b1, 8'h96, 1'b0, 8, -1, 0, seen, aoe, st);
    // SCL was just pulled low for the 8th fall.
    n_tests++; if (sda_pad_oe !== 1'b0) begin n_fail++; $display("FAIL rx_ack0_pre got=%b exp=0", sda_pad_oe); end
    @(negedge pclk);
    bad = 0;
    if (sda_pad_oe !== 1'b1) bad++;
    repeat (3) begin @(negedge pclk); if (sda_pad_oe !== 1'b1) bad++; end
    scl = 1'b1;
    repeat (4) begin @(negedge pclk); if (sda_pad_oe !== 1'b1) bad++; end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rx_ack0_drive got=%0d exp=0 bad cycles", bad); end
    scl = 1'b0;
    n_tests++; if (sda_pad_oe !== 1'b1) begin n_fail++; $display("FAIL rx_ack0_hold got=%b exp=1", sda_pad_oe); end
    @(negedge pclk);
    exp_rx = 8'h96;
    n_tests++; if (sda_pad_oe !== 1'b0 || byte_done !== 1'b1) begin n_fail++; $display("FAIL rx_ack0_end got=%b/%b exp=0/1", sda_pad_oe, byte_done); end
    n_tests++; if (rx_data !== exp_rx) begin n_fail++; $display("FAIL rx_ack0_data got=%h exp=%h", rx_data, exp_rx); end
  endtask

  task automatic test_random;
    logic [7:0] seen; logic aoe; bit st;
    bit dir; bit ats; bit sack; logic [7:0] d;
    for (int it = 0; it < 8; it++) begin
      dir = 1'($urandom_range(0, 1));
      ats = 1'($urandom_range(0, 1));
      sack = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      start_byte(dir, d, ats);
      n_tests++; if (busy !== 1'b1 || sda_pad_oe !== (dir ? 1'b0 : ~d[7])) begin n_fail++; $display("FAIL rand%0d_accept got=%b/%b exp=1/%b", it, busy, sda_pad_oe, dir ? 1'b0 : ~d[7]); end
      clock_bits(dir, d, sack, 9, -1, 0, seen, aoe, st);
      n_tests++; if (seen !== d) begin n_fail++; $display("FAIL rand%0d_bus got=%h exp=%h", it, seen, d); end
      n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL rand%0d_stable got=%b exp=1", it, st); end
      n_tests++; if (aoe !== (dir ? ~ats : 1'b0)) begin n_fail++; $display("FAIL rand%0d_ackoe got=%b exp=%b", it, aoe, dir ? ~ats : 1'b0); end
      @(negedge pclk);
      n_tests++; if (byte_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_done got=%b/%b exp=1/0", it, byte_done, busy); end
      if (dir) begin
        exp_rx = d;
        n_tests++; if (rx_data !== exp_rx) begin n_fail++; $display("FAIL rand%0d_rx got=%h exp=%h", it, rx_data, exp_rx); end
      end else begin
        n_tests++; if (ack_received !== sack) begin n_fail++; $display("FAIL rand%0d_ackrx got=%b exp=%b", it, ack_received, sack); end
      end
      repeat (2) @(negedge pclk);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seen; logic aoe; bit st;
    logic [7:0] d;
    d = 8'($urandom);
    start_byte(1'b0, d, 1'b1);
    // A second request while busy must not disturb the byte in flight.
    byte_dir = 1'b1; tx_data = ~d; byte_start = 1'b1;
    @(negedge pclk);
    byte_start = 1'b0;
    clock_bits(1'b0, 8'h00, 1'b1, 9, -1, 0, seen, aoe, st);
    n_tests++; if (seen !== d) begin n_fail++; $display("FAIL b2b_ignore got=%h exp=%h", seen, d); end
    @(negedge pclk);
    n_tests++; if (byte_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got=%b exp=1", byte_done); end
    n_tests++; if (ack_received !== 1'b1) begin n_fail++; $display("FAIL b2b_nack got=%b exp=1", ack_received); end
    start_byte(1'b1, 8'h00, 1'b1);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got=%b exp=1", busy); end
    clock_bits(1'b1, ~d, 1'b0, 9, -1, 0, seen, aoe, st);
    @(negedge pclk);
    exp_rx = ~d;
    n_tests++; if (rx_data !== exp_rx) begin n_fail++; $display("FAIL b2b_rx got=%h exp=%h", rx_data, exp_rx); end
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_arbitration;
    logic [7:0] seen; logic aoe; bit st;
    int d0; int a0;
    d0 = n_done; a0 = n_arb;
    start_byte(1'b0, 8'hFF, 1'b1);
    clock_bits(1'b0, 8'h00, 1'b0, 2, -1, 0, seen, aoe, st);
    repeat (4) @(negedge pclk);
    scl = 1'b1; slave_low = 1'b1;
    @(negedge pclk);
    n_tests++; if (arb_lost !== 1'b1) begin n_fail++; $display("FAIL arb_pulse got=%b exp=1", arb_lost); end
    n_tests++; if (busy !== 1'b0 || sda_pad_oe !== 1'b0) begin n_fail++; $display("FAIL arb_release got=%b/%b exp=0/0", busy, sda_pad_oe); end
    repeat (3) @(negedge pclk);
    scl = 1'b0; slave_low = 1'b0;
    repeat (3) @(negedge pclk);
    n_tests++; if (n_arb - a0 !== 1) begin n_fail++; $display("FAIL arb_count got=%0d exp=1", n_arb - a0); end
    n_tests++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL arb_nodone got=%0d exp=0", n_done - d0); end
    n_tests++; if (rx_data !== exp_rx) begin n_fail++; $display("FAIL arb_rx_hold got=%h exp=%h", rx_data, exp_rx); end
  endtask

  task automatic test_abort;
    logic [7:0] seen; logic aoe; bit st;
    int d0; int a0;
    d0 = n_done; a0 = n_arb;
    start_byte(1'b0, 8'h00, 1'b1);
    clock_bits(1'b0, 8'h00, 1'b0, 4, -1, 0, seen, aoe, st);
    @(negedge pclk);
    n_tests++; if (sda_pad_oe !== 1'b1) begin n_fail++; $display("FAIL abort_pre got=%b exp=1", sda_pad_oe); end
    abort = 1'b1;
    @(negedge pclk);
    abort = 1'b0;
    n_tests++; if (busy !== 1'b0 || sda_pad_oe !== 1'b0) begin n_fail++; $display("FAIL abort_idle got=%b/%b exp=0/0", busy, sda_pad_oe); end
    abort = 1'b1;
    start_byte(1'b0, 8'h00, 1'b1);
    abort = 1'b0;
    n_tests++; if (busy !== 1'b0 || sda_pad_oe !== 1'b0) begin n_fail++; $display("FAIL abort_start got=%b/%b exp=0/0", busy, sda_pad_oe); end
    repeat (3) @(negedge pclk);
    n_tests++; if ((n_done - d0) !== 0 || (n_arb - a0) !== 0) begin n_fail++; $display("FAIL abort_pulses got=%0d/%0d exp=0/0", n_done - d0, n_arb - a0); end
  endtask

  task automatic test_stretch;
    logic [7:0] seen; logic aoe; bit st;
    start_byte(1'b0, 8'h81, 1'b1);
    clock_bits(1'b0, 8'h00, 1'b0, 9, 1, 50, seen, aoe, st);
    n_tests++; if (seen !== 8'h81) begin n_fail++; $display("FAIL stretch_bits got=%h exp=81", seen); end
    @(negedge pclk);
    n_tests++; if (byte_done !== 1'b1 || ack_received !== 1'b0) begin n_fail++; $display("FAIL stretch_done got=%b/%b exp=1/0", byte_done, ack_received); end
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_reset_in_ack;
    logic [7:0] seen; logic aoe; bit st;
    start_byte(1'b0, 8'h5A, 1'b1);
    clock_bits(1'b0, 8'h00, 1'b1, 9, -1, 0, seen, aoe, st);
    @(negedge pclk);
    n_tests++; if (ack_received !== 1'b1 || rx_data !== exp_rx) begin n_fail++; $display("FAIL rst_pre got=%b/%h exp=1/%h", ack_received, rx_data, exp_rx); end
    start_byte(1'b1, 8'h00, 1'b0);
    clock_bits(1'b1, 8'hC3, 1'b0, 8, -1, 0, seen, aoe, st);
    repeat (3) @(negedge pclk);
    scl = 1'b1;
    repeat (2) @(negedge pclk);
    n_tests++; if (sda_pad_oe !== 1'b1) begin n_fail++; $display("FAIL rst_ackslot got=%b exp=1", sda_pad_oe); end
    preset = 1'b1;
    @(negedge pclk);
    n_tests++; if (sda_pad_oe !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_oe_busy got=%b/%b exp=0/0", sda_pad_oe, busy); end
    n_tests++; if (byte_done !== 1'b0 || arb_lost !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulses got=%b/%b exp=0/0", byte_done, arb_lost); end
    n_tests++; if (rx_data !== 8'h00 || ack_received !== 1'b0) begin n_fail++; $display("FAIL rst_mid_regs got=%h/%b exp=00/0", rx_data, ack_received); end
    preset = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  initial begin
    test_reset();
    test_tx_a5();
    test_rx_nack();
    test_rx_ack0();
    test_random();
    test_back_to_back();
    test_arbitration();
    test_abort();
    test_stretch();
    test_reset_in_ack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
